// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the 5-stage core's hazard control.
//   hz_state_t    : hazard controller state (IDLE, FP_BUSY)
//   REG_SEL_*     : register-file selector encodings (int / float)
//   hz_ctrl_t     : bundle of pipeline write/flush/bubble controls
//   CTRL_RUN      : control bundle for a freely advancing pipeline
//   STALL_CNT_MAX : saturation value of the stall-cycle counter
// -----------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        FP_BUSY = 1'b1
    } hz_state_t;

    localparam logic REG_SEL_INT   = 1'b0;
    localparam logic REG_SEL_FLOAT = 1'b1;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_bubble;
        logic ex_mem_bubble;
        logic fp_busy;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN = '{
        pc_write:      1'b1,
        if_id_write:   1'b1,
        if_id_flush:   1'b0,
        id_ex_write:   1'b1,
        id_ex_bubble:  1'b0,
        ex_mem_bubble: 1'b0,
        fp_busy:       1'b0
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // True when a used source operand names the same architectural register
    // (number and register file) as the EX-stage destination.
    function automatic logic src_match(
        input logic [4:0] rs,
        input logic       rs_sel,
        input logic       uses,
        input logic [4:0] rd,
        input logic       rd_sel
    );
        return uses && (rs == rd) && (rs_sel == rd_sel);
    endfunction

endpackage

// File: rtl/fp_busy_counter.sv
// -----------------------------------------------------------------------------
// fp_busy_counter
// Tracks how long a multi-cycle FP operation still occupies EX.
// Ports:
//   clk_i          : core clock
//   rst_i          : synchronous, active-high reset
//   start_fmul_i   : fmul entered EX this cycle
//   start_fdiv_i   : fdiv entered EX this cycle (wins over fmul)
//   fp_stall_o     : EX is held by an FP op this cycle
//   state_o        : current controller state
// An op of occupancy N stalls N-1 cycles: the start cycle plus N-2 more
// counted down in FP_BUSY. The cycle where cnt reaches 0 is the release.
// -----------------------------------------------------------------------------
module fp_busy_counter
    import riscv_pkg::*;
#(
    parameter int unsigned FMUL_CYCLES = 3,
    parameter int unsigned FDIV_CYCLES = 8
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      start_fmul_i,
    input  logic      start_fdiv_i,
    output logic      fp_stall_o,
    output hz_state_t state_o
);

    localparam int unsigned MaxCycles = max_u(FMUL_CYCLES, FDIV_CYCLES);
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    hz_state_t       state_q;
    logic [CntW-1:0] cnt_q;

    int unsigned     op_len;
    logic            launch;
    logic [CntW-1:0] cnt_load;

    always_comb begin
        op_len   = start_fdiv_i ? FDIV_CYCLES : FMUL_CYCLES;
        // Single-cycle ops never hold EX, so they do not launch a stall.
        launch   = (state_q == IDLE) && (start_fdiv_i || start_fmul_i) && (op_len >= 2);
        cnt_load = launch ? CntW'(op_len - 32'd2) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (launch) begin
                        state_q <= FP_BUSY;
                        cnt_q   <= cnt_load;
                    end
                end
                FP_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // The stall has to appear in the start cycle itself, so it is decoded
    // from the current state and the start inputs rather than registered.
    always_comb begin
        fp_stall_o = 1'b0;
        if (!rst_i) begin
            fp_stall_o = launch || ((state_q == FP_BUSY) && (cnt_q != '0));
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// ID-stage hazard controller: load-use stalls, multi-cycle FP stalls and
// branch-mispredict flushes, plus a saturating stalled-cycle counter.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   if_id_rs1/rs2, *_sel, uses_* : source operands of the ID instruction
//   id_ex_rd, id_ex_rd_sel       : destination of the EX instruction
//   id_ex_memread                : EX instruction is a load
//   ex_start_fmul/fdiv           : multi-cycle FP op entered EX
//   branch_flush                 : mispredict resolved in EX
//   pc_write, if_id_write,
//   id_ex_write                  : pipeline register write enables
//   if_id_flush, id_ex_bubble,
//   ex_mem_bubble                : flush / NOP insertion controls
//   fp_busy                      : FP op holding EX
//   stall_cycles                 : saturating count of cycles with pc_write=0
// -----------------------------------------------------------------------------
module hazard_stall_unit
    import riscv_pkg::*;
#(
    parameter int unsigned FMUL_CYCLES = 3,
    parameter int unsigned FDIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  if_id_rs1,
    input  logic [4:0]  if_id_rs2,
    input  logic        if_id_rs1_sel,
    input  logic        if_id_rs2_sel,
    input  logic        if_id_uses_rs1,
    input  logic        if_id_uses_rs2,
    input  logic [4:0]  id_ex_rd,
    input  logic        id_ex_rd_sel,
    input  logic        id_ex_memread,
    input  logic        ex_start_fmul,
    input  logic        ex_start_fdiv,
    input  logic        branch_flush,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_write,
    output logic        id_ex_bubble,
    output logic        ex_mem_bubble,
    output logic        fp_busy,
    output logic [15:0] stall_cycles
);

    hz_state_t   state;
    logic        fp_stall;
    logic        flush_act;
    logic        load_use;
    hz_ctrl_t    ctrl;
    logic [15:0] stall_q;

    // A flush discards the branch's shadow, so an FP start in the same cycle
    // is not launched.
    assign flush_act = branch_flush && (state == IDLE);

    fp_busy_counter #(
        .FMUL_CYCLES (FMUL_CYCLES),
        .FDIV_CYCLES (FDIV_CYCLES)
    ) u_fp_busy_counter (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_fmul_i (ex_start_fmul && !flush_act),
        .start_fdiv_i (ex_start_fdiv && !flush_act),
        .fp_stall_o   (fp_stall),
        .state_o      (state)
    );

    // Integer x0 never carries a dependence; float f0 is a real register.
    always_comb begin
        load_use = id_ex_memread
                && ((id_ex_rd != 5'd0) || (id_ex_rd_sel == REG_SEL_FLOAT))
                && (src_match(if_id_rs1, if_id_rs1_sel, if_id_uses_rs1, id_ex_rd, id_ex_rd_sel)
                 || src_match(if_id_rs2, if_id_rs2_sel, if_id_uses_rs2, id_ex_rd, id_ex_rd_sel));
    end

    // Priority: reset > flush > FP stall > load-use. Load-use is naturally
    // masked while the FP op holds EX and reappears in the release cycle.
    always_comb begin
        ctrl = CTRL_RUN;
        if (rst) begin
            ctrl = CTRL_RUN;
        end else if (flush_act) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
        end else if (fp_stall) begin
            ctrl.pc_write      = 1'b0;
            ctrl.if_id_write   = 1'b0;
            ctrl.id_ex_write   = 1'b0;
            ctrl.ex_mem_bubble = 1'b1;
            ctrl.fp_busy       = 1'b1;
        end else if (load_use) begin
            // ID/EX keeps writing so the bubble actually lands.
            ctrl.pc_write     = 1'b0;
            ctrl.if_id_write  = 1'b0;
            ctrl.id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (!ctrl.pc_write && (stall_q != STALL_CNT_MAX)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_write   = ctrl.id_ex_write;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign ex_mem_bubble = ctrl.ex_mem_bubble;
    assign fp_busy       = ctrl.fp_busy;
    assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit. Inputs change on the falling edge;
// combinational controls are sampled 1ns later, counters after the next
// rising edge.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  if_id_rs1, if_id_rs2, id_ex_rd;
    logic        if_id_rs1_sel, if_id_rs2_sel, if_id_uses_rs1, if_id_uses_rs2;
    logic        id_ex_rd_sel, id_ex_memread, ex_start_fmul, ex_start_fdiv, branch_flush;
    logic        pc_write, if_id_write, if_id_flush, id_ex_write;
    logic        id_ex_bubble, ex_mem_bubble, fp_busy;
    logic [15:0] stall_cycles;
    logic [6:0]  ctl;

    int checks = 0;
    int errors = 0;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, fp_busy}
    localparam logic [6:0] CTL_RUN = 7'b1101000;
    localparam logic [6:0] CTL_LU  = 7'b0001100;
    localparam logic [6:0] CTL_FP  = 7'b0000011;
    localparam logic [6:0] CTL_FL  = 7'b1111100;

    always #5 clk = ~clk;

    assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_write,
                  id_ex_bubble, ex_mem_bubble, fp_busy};

    hazard_stall_unit #(
        .FMUL_CYCLES (3),
        .FDIV_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .if_id_rs1_sel  (if_id_rs1_sel),
        .if_id_rs2_sel  (if_id_rs2_sel),
        .if_id_uses_rs1 (if_id_uses_rs1),
        .if_id_uses_rs2 (if_id_uses_rs2),
        .id_ex_rd       (id_ex_rd),
        .id_ex_rd_sel   (id_ex_rd_sel),
        .id_ex_memread  (id_ex_memread),
        .ex_start_fmul  (ex_start_fmul),
        .ex_start_fdiv  (ex_start_fdiv),
        .branch_flush   (branch_flush),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_write    (id_ex_write),
        .id_ex_bubble   (id_ex_bubble),
        .ex_mem_bubble  (ex_mem_bubble),
        .fp_busy        (fp_busy),
        .stall_cycles   (stall_cycles)
    );

    task automatic clear_inputs();
        if_id_rs1 = 5'd0; if_id_rs2 = 5'd0; id_ex_rd = 5'd0;
        if_id_rs1_sel = 1'b0; if_id_rs2_sel = 1'b0;
        if_id_uses_rs1 = 1'b0; if_id_uses_rs2 = 1'b0;
        id_ex_rd_sel = 1'b0; id_ex_memread = 1'b0;
        ex_start_fmul = 1'b0; ex_start_fdiv = 1'b0; branch_flush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_x5_hazard();
        id_ex_memread = 1'b1; id_ex_rd = 5'd5; id_ex_rd_sel = 1'b0;
        if_id_rs2 = 5'd5; if_id_rs2_sel = 1'b0; if_id_uses_rs2 = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        set_x5_hazard();
        ex_start_fdiv = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_RUN);
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_stall_cycles: got %0d expected 0", stall_cycles);
        end
        checks++;
        if (ctl !== CTL_RUN) begin
            errors++;
            $display("FAIL reset_release_ctl: got %b expected %b", ctl, CTL_RUN);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_x5_hazard();
        #1;
        checks++;
        if (ctl !== CTL_LU) begin
            errors++;
            $display("FAIL load_use_ctl: got %b expected %b", ctl, CTL_LU);
        end
        @(negedge clk);
        id_ex_memread = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            errors++;
            $display("FAIL load_use_one_cycle: got %b expected %b", ctl, CTL_RUN);
        end
        checks++;
        if (stall_cycles !== 16'd1) begin
            errors++;
            $display("FAIL load_use_count: got %0d expected 1", stall_cycles);
        end
    endtask

    task automatic test_cross_file();
        do_reset();
        set_x5_hazard();
        if_id_rs2_sel = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            errors++;
            $display("FAIL cross_file_int_float: got %b expected %b", ctl, CTL_RUN);
        end
        @(negedge clk);
        // Matching rs1 but not used; integer x0 destination
        clear_inputs();
        id_ex_memread = 1'b1; id_ex_rd = 5'd7; if_id_rs1 = 5'd7;
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            errors++;
            $display("FAIL unused_rs1: got %b expected %b", ctl, CTL_RUN);
        end
        id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_uses_rs1 = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            errors++;
            $display("FAIL int_x0: got %b expected %b", ctl, CTL_RUN);
        end
        @(negedge clk);
        // flw f0 then ID reads f0
        id_ex_rd_sel = 1'b1; if_id_rs1_sel = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_LU) begin
            errors++;
            $display("FAIL float_f0: got %b expected %b", ctl, CTL_LU);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (stall_cycles !== 16'd1) begin
            errors++;
            $display("FAIL cross_file_count: got %0d expected 1", stall_cycles);
        end
    endtask

    task automatic test_fdiv();
        logic [6:0] exp_ctl;
        do_reset();
        ex_start_fdiv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) ex_start_fdiv = 1'b0;
            // Starts and a load-use pattern during FP_BUSY must be ignored
            if (i == 2) set_x5_hazard();
            if (i == 3) begin
                id_ex_memread = 1'b0;
                ex_start_fmul = 1'b1;
            end
            #1;
            exp_ctl = (i < 7) ? CTL_FP : CTL_RUN;
            checks++;
            if (ctl !== exp_ctl) begin
                errors++;
                $display("FAIL fdiv_cycle%0d: got %b expected %b", i, ctl, exp_ctl);
            end
            @(negedge clk);
        end
        clear_inputs();
        #1;
        checks++;
        if (stall_cycles !== 16'd7) begin
            errors++;
            $display("FAIL fdiv_count: got %0d expected 7", stall_cycles);
        end
    endtask

    task automatic test_fmul_priority();
        logic [6:0] exp_ctl;
        do_reset();
        ex_start_fmul = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) ex_start_fmul = 1'b0;
            #1;
            exp_ctl = (i < 2) ? CTL_FP : CTL_RUN;
            checks++;
            if (ctl !== exp_ctl) begin
                errors++;
                $display("FAIL fmul_cycle%0d: got %b expected %b", i, ctl, exp_ctl);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (stall_cycles !== 16'd2) begin
            errors++;
            $display("FAIL fmul_count: got %0d expected 2", stall_cycles);
        end
        // Both starts together: fdiv occupancy applies
        ex_start_fmul = 1'b1; ex_start_fdiv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                ex_start_fmul = 1'b0; ex_start_fdiv = 1'b0;
            end
            #1;
            exp_ctl = (i < 7) ? CTL_FP : CTL_RUN;
            checks++;
            if (ctl !== exp_ctl) begin
                errors++;
                $display("FAIL both_start_cycle%0d: got %b expected %b", i, ctl, exp_ctl);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_flush();
        do_reset();
        set_x5_hazard();
        branch_flush = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_FL) begin
            errors++;
            $display("FAIL flush_over_load_use: got %b expected %b", ctl, CTL_FL);
        end
        @(negedge clk);
        clear_inputs();
        branch_flush = 1'b1;
        ex_start_fdiv = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_FL) begin
            errors++;
            $display("FAIL flush_over_fp_start: got %b expected %b", ctl, CTL_FL);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL flush_count: got %0d expected 0", stall_cycles);
        end
    endtask

    task automatic test_reset_mid_fp();
        do_reset();
        ex_start_fdiv = 1'b1;
        @(negedge clk);
        ex_start_fdiv = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            errors++;
            $display("FAIL reset_mid_fp_forced: got %b expected %b", ctl, CTL_RUN);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            errors++;
            $display("FAIL reset_mid_fp_idle: got %b expected %b", ctl, CTL_RUN);
        end
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_fp_count: got %0d expected 0", stall_cycles);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        // Held start gives 7 stalled cycles out of every 8: about 65625 stalls
        ex_start_fdiv = 1'b1;
        repeat (75000) @(negedge clk);
        ex_start_fdiv = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (stall_cycles !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation: got %h expected ffff", stall_cycles);
        end
        checks++;
        if (ctl !== CTL_RUN) begin
            errors++;
            $display("FAIL saturation_idle: got %b expected %b", ctl, CTL_RUN);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_cross_file();
        test_fdiv();
        test_fmul_priority();
        test_branch_flush();
        test_reset_mid_fp();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
